// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the decode stage: instruction codes, status codes,
// register-index defaults and the field values of an E-register bubble.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam int REG_AW_DEF  = 4;
    localparam int RNONE_DEF   = 15;
    localparam int RSP_IDX_DEF = 4;

    localparam logic [3:0] BUBBLE_STAT  = S_AOK;
    localparam logic [3:0] BUBBLE_ICODE = I_NOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two combinational read ports, two write ports.
// When both write ports hit the same register the M port wins (popq %rsp).
module y86_regfile #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15,
    parameter int REG_AW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] we_idx,
    input  logic [DATA_W-1:0] we_data,
    input  logic [REG_AW-1:0] wm_idx,
    input  logic [DATA_W-1:0] wm_data,
    input  logic [REG_AW-1:0] ra_idx,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_idx,
    output logic [DATA_W-1:0] rb_data
);

    localparam logic [REG_AW-1:0] RNONE = '1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we_idx != RNONE && we_idx == REG_AW'(i)) regs_d[i] = we_data;
            if (wm_idx != RNONE && wm_idx == REG_AW'(i)) regs_d[i] = wm_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Unmatched indices (RNONE or beyond NUM_REGS) fall through to zero.
    always_comb begin
        ra_data = '0;
        rb_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ra_idx != RNONE && ra_idx == REG_AW'(i)) ra_data = regs_q[i];
            if (rb_idx != RNONE && rb_idx == REG_AW'(i)) rb_data = regs_q[i];
        end
    end

endmodule

// File: rtl/y86_decode_stage.sv
// Y86-64 decode stage: source/destination selection, five-source forwarding
// into valA/valB, and the E pipeline register with stall/bubble control.
module y86_decode_stage
    import y86_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int RSP_IDX  = RSP_IDX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        D_stat,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [REG_AW-1:0] D_rA,
    input  logic [REG_AW-1:0] D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [REG_AW-1:0] e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [REG_AW-1:0] M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [REG_AW-1:0] M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [REG_AW-1:0] W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [REG_AW-1:0] W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    input  logic              E_stall,
    input  logic              E_bubble,
    output logic [3:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [REG_AW-1:0] E_dstE,
    output logic [REG_AW-1:0] E_dstM,
    output logic [REG_AW-1:0] E_srcA,
    output logic [REG_AW-1:0] E_srcB,
    output logic [REG_AW-1:0] d_srcA,
    output logic [REG_AW-1:0] d_srcB
);

    localparam logic [REG_AW-1:0] RNONE = '1;
    localparam logic [REG_AW-1:0] RSP   = REG_AW'(RSP_IDX);

    logic [REG_AW-1:0] d_dstE, d_dstM;
    logic [DATA_W-1:0] rf_a, rf_b, d_valA, d_valB;

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            I_RRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
            I_IRMOVQ: d_dstE = D_rB;
            I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
            I_MRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
            I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
            I_CALL:   begin d_srcB = RSP; d_dstE = RSP; end
            I_RET:    begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
            I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP; d_dstE = RSP; end
            I_POPQ:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = D_rA; end
            default:  ;
        endcase
    end

    y86_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_idx  (W_dstE),
        .we_data (W_valE),
        .wm_idx  (W_dstM),
        .wm_data (W_valM),
        .ra_idx  (d_srcA),
        .ra_data (rf_a),
        .rb_idx  (d_srcB),
        .rb_data (rf_b)
    );

    // Youngest producer first; W ports cover the same-cycle register write.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rf_val
    );
        if (src == RNONE || int'(src) >= NUM_REGS) return '0;
        if (src == e_dstE) return e_valE;
        if (src == M_dstM) return m_valM;
        if (src == M_dstE) return M_valE;
        if (src == W_dstM) return W_valM;
        if (src == W_dstE) return W_valE;
        return rf_val;
    endfunction

    always_comb begin
        d_valB = fwd_sel(d_srcB, rf_b);
        if (D_icode == I_JXX || D_icode == I_CALL) d_valA = D_valP;
        else d_valA = fwd_sel(d_srcA, rf_a);
    end

    logic [3:0]        stat_q, stat_d, icode_q, icode_d, ifun_q, ifun_d;
    logic [DATA_W-1:0] valc_q, valc_d, vala_q, vala_d, valb_q, valb_d;
    logic [REG_AW-1:0] dste_q, dste_d, dstm_q, dstm_d, srca_q, srca_d, srcb_q, srcb_d;

    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        valc_d  = valc_q;
        vala_d  = vala_q;
        valb_d  = valb_q;
        dste_d  = dste_q;
        dstm_d  = dstm_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        if (E_bubble) begin
            stat_d  = BUBBLE_STAT;
            icode_d = BUBBLE_ICODE;
            ifun_d  = BUBBLE_IFUN;
            valc_d  = '0;
            vala_d  = '0;
            valb_d  = '0;
            dste_d  = RNONE;
            dstm_d  = RNONE;
            srca_d  = RNONE;
            srcb_d  = RNONE;
        end else if (!E_stall) begin
            stat_d  = D_stat;
            icode_d = D_icode;
            ifun_d  = D_ifun;
            valc_d  = D_valC;
            vala_d  = d_valA;
            valb_d  = d_valB;
            dste_d  = d_dstE;
            dstm_d  = d_dstM;
            srca_d  = d_srcA;
            srcb_d  = d_srcB;
        end
    end

    // Reset state is a bubble so a freshly reset pipe executes a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q  <= BUBBLE_STAT;
            icode_q <= BUBBLE_ICODE;
            ifun_q  <= BUBBLE_IFUN;
            valc_q  <= '0;
            vala_q  <= '0;
            valb_q  <= '0;
            dste_q  <= RNONE;
            dstm_q  <= RNONE;
            srca_q  <= RNONE;
            srcb_q  <= RNONE;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            valc_q  <= valc_d;
            vala_q  <= vala_d;
            valb_q  <= valb_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
        end
    end

    assign E_stat  = stat_q;
    assign E_icode = icode_q;
    assign E_ifun  = ifun_q;
    assign E_valC  = valc_q;
    assign E_valA  = vala_q;
    assign E_valB  = valb_q;
    assign E_dstE  = dste_q;
    assign E_dstM  = dstm_q;
    assign E_srcA  = srca_q;
    assign E_srcB  = srcb_q;

endmodule

// File: tb/tb_y86_decode_stage.sv
// Self-checking bench for y86_decode_stage: fixed vectors, stall/bubble/reset
// sequences and randomized traffic against a behavioural model.
module tb_y86_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic        E_stall, E_bubble;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, d_srcA, d_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    y86_decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .E_stall(E_stall), .E_bubble(E_bubble),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB), .d_srcA(d_srcA), .d_srcB(d_srcB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  stat, icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM, srcA, srcB;
    } exp_t;

    typedef struct {
        logic [3:0]  icode, rA, rB;
        logic [63:0] valP;
        logic [3:0]  edE;  logic [63:0] evE;
        logic [3:0]  mdM;  logic [63:0] mvM;
        logic [3:0]  wdE;  logic [63:0] wvE;
        logic [3:0]  wdM;  logic [63:0] wvM;
        logic [63:0] xA, xB;
        logic [3:0]  xdE, xdM, xsA, xsB;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] ref_regs [15];
    exp_t        exp_q;
    exp_t        bubble_e;
    vec_t        vecs [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
        return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] src);
        logic [3:0]  pd [5];
        logic [63:0] pv [5];
        pd = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        pv = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        if (src == 4'hF || src >= 4'd15) return 64'd0;
        foreach (pd[k]) if (pd[k] == src) return pv[k];
        return ref_regs[src];
    endfunction

    function automatic vec_t mkv(
        input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vp,
        input logic [3:0] ede, input logic [63:0] eve, input logic [3:0] mdm, input logic [63:0] mvm,
        input logic [3:0] wde, input logic [63:0] wve, input logic [3:0] wdm, input logic [63:0] wvm,
        input logic [63:0] xa, input logic [63:0] xb,
        input logic [3:0] xde, input logic [3:0] xdm, input logic [3:0] xsa, input logic [3:0] xsb);
        vec_t v;
        v.icode = ic; v.rA = ra; v.rB = rb; v.valP = vp;
        v.edE = ede; v.evE = eve; v.mdM = mdm; v.mvM = mvm;
        v.wdE = wde; v.wvE = wve; v.wdM = wdm; v.wvM = wvm;
        v.xA = xa; v.xB = xb; v.xdE = xde; v.xdM = xdm; v.xsA = xsa; v.xsB = xsb;
        return v;
    endfunction

    task automatic set_idle();
        D_stat = 4'h1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = 64'd0; D_valP = 64'd0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
        E_stall = 1'b0; E_bubble = 1'b0;
    endtask

    task automatic model_reset();
        foreach (ref_regs[k]) ref_regs[k] = 64'd0;
        exp_q = bubble_e;
    endtask

    task automatic check_e(input string tag);
        chk({tag, ".stat"},  {60'd0, E_stat},  {60'd0, exp_q.stat});
        chk({tag, ".icode"}, {60'd0, E_icode}, {60'd0, exp_q.icode});
        chk({tag, ".ifun"},  {60'd0, E_ifun},  {60'd0, exp_q.ifun});
        chk({tag, ".valC"},  E_valC, exp_q.valC);
        chk({tag, ".valA"},  E_valA, exp_q.valA);
        chk({tag, ".valB"},  E_valB, exp_q.valB);
        chk({tag, ".dstE"},  {60'd0, E_dstE},  {60'd0, exp_q.dstE});
        chk({tag, ".dstM"},  {60'd0, E_dstM},  {60'd0, exp_q.dstM});
        chk({tag, ".srcA"},  {60'd0, E_srcA},  {60'd0, exp_q.srcA});
        chk({tag, ".srcB"},  {60'd0, E_srcB},  {60'd0, exp_q.srcB});
    endtask

    // One clock: predict the E register and the register-file update, then compare.
    task automatic tick(input string tag);
        exp_t nx;
        #1;
        chk({tag, ".d_srcA"}, {60'd0, d_srcA}, {60'd0, m_srcA(D_icode, D_rA)});
        chk({tag, ".d_srcB"}, {60'd0, d_srcB}, {60'd0, m_srcB(D_icode, D_rB)});
        if (E_bubble) nx = bubble_e;
        else if (E_stall) nx = exp_q;
        else begin
            nx.stat = D_stat; nx.icode = D_icode; nx.ifun = D_ifun; nx.valC = D_valC;
            nx.srcA = m_srcA(D_icode, D_rA);
            nx.srcB = m_srcB(D_icode, D_rB);
            nx.dstE = m_dstE(D_icode, D_rB);
            nx.dstM = m_dstM(D_icode, D_rA);
            nx.valA = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_read(nx.srcA);
            nx.valB = m_read(nx.srcB);
        end
        if (W_dstE < 4'd15) ref_regs[W_dstE] = W_valE;
        if (W_dstM < 4'd15) ref_regs[W_dstM] = W_valM;
        @(posedge clk);
        #1;
        exp_q = nx;
        check_e(tag);
    endtask

    initial begin
        bubble_e = '{stat: 4'h1, icode: 4'h1, ifun: 4'h0, valC: 64'd0, valA: 64'd0, valB: 64'd0,
                     dstE: 4'hF, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF};
        vecs[0]  = mkv(4'h1, 4'hF, 4'hF, 64'h0,  4'hF, 0, 4'hF, 0, 4'h3, 64'd33, 4'h5, 64'd55,
                       64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF);
        vecs[1]  = mkv(4'h6, 4'h3, 4'h5, 64'h0,  4'hF, 0, 4'hF, 0, 4'hF, 0, 4'hF, 0,
                       64'd33, 64'd55, 4'h5, 4'hF, 4'h3, 4'h5);
        vecs[2]  = mkv(4'h2, 4'h2, 4'h7, 64'h0,  4'h2, 64'd7, 4'h2, 64'd9, 4'hF, 0, 4'hF, 0,
                       64'd7, 64'd0, 4'h7, 4'hF, 4'h2, 4'hF);
        vecs[3]  = mkv(4'h2, 4'h2, 4'h7, 64'h0,  4'hF, 64'd7, 4'h2, 64'd9, 4'hF, 0, 4'hF, 0,
                       64'd9, 64'd0, 4'h7, 4'hF, 4'h2, 4'hF);
        vecs[4]  = mkv(4'h8, 4'hF, 4'h0, 64'h40, 4'hF, 0, 4'hF, 0, 4'hF, 0, 4'hF, 0,
                       64'h40, 64'd0, 4'h4, 4'hF, 4'hF, 4'h4);
        vecs[5]  = mkv(4'hB, 4'h6, 4'hF, 64'h0,  4'hF, 0, 4'hF, 0, 4'h4, 64'h10, 4'h4, 64'h20,
                       64'h20, 64'h20, 4'h4, 4'h6, 4'h4, 4'h4);
        vecs[6]  = mkv(4'h2, 4'h4, 4'h1, 64'h0,  4'hF, 0, 4'hF, 0, 4'hF, 0, 4'hF, 0,
                       64'h20, 64'd0, 4'h1, 4'hF, 4'h4, 4'hF);
        vecs[7]  = mkv(4'h3, 4'hF, 4'h3, 64'h0,  4'hF, 0, 4'hF, 0, 4'hF, 0, 4'hF, 0,
                       64'd0, 64'd0, 4'h3, 4'hF, 4'hF, 4'hF);
        vecs[8]  = mkv(4'h5, 4'h1, 4'h3, 64'h0,  4'hF, 0, 4'hF, 0, 4'hF, 0, 4'hF, 0,
                       64'd0, 64'd33, 4'hF, 4'h1, 4'hF, 4'h3);
        vecs[9]  = mkv(4'h7, 4'hF, 4'hF, 64'h1234, 4'hF, 0, 4'hF, 0, 4'hF, 0, 4'hF, 0,
                       64'h1234, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF);
        vecs[10] = mkv(4'h4, 4'h5, 4'h3, 64'h0,  4'hF, 0, 4'hF, 0, 4'hF, 0, 4'hF, 0,
                       64'd55, 64'd33, 4'hF, 4'hF, 4'h5, 4'h3);
        vecs[11] = mkv(4'hA, 4'h3, 4'hF, 64'h0,  4'hF, 0, 4'hF, 0, 4'hF, 0, 4'hF, 0,
                       64'd33, 64'h20, 4'h4, 4'hF, 4'h3, 4'h4);
        vecs[12] = mkv(4'h9, 4'hF, 4'hF, 64'h0,  4'hF, 0, 4'hF, 0, 4'hF, 0, 4'hF, 0,
                       64'h20, 64'h20, 4'h4, 4'hF, 4'h4, 4'h4);

        set_idle();
        D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_e("reset");
        chk("reset.d_srcA", {60'd0, d_srcA}, 64'd1);
        chk("reset.d_srcB", {60'd0, d_srcB}, 64'd2);
        rst_n = 1'b1;
        tick("post_reset");
        chk("post_reset.valA_zero", E_valA, 64'd0);
        chk("post_reset.valB_zero", E_valB, 64'd0);

        for (int i = 0; i < 13; i++) begin
            set_idle();
            D_icode = vecs[i].icode; D_rA = vecs[i].rA; D_rB = vecs[i].rB; D_valP = vecs[i].valP;
            D_valC = 64'hC0DE_0000 + 64'(i);
            e_dstE = vecs[i].edE; e_valE = vecs[i].evE;
            M_dstM = vecs[i].mdM; m_valM = vecs[i].mvM;
            W_dstE = vecs[i].wdE; W_valE = vecs[i].wvE;
            W_dstM = vecs[i].wdM; W_valM = vecs[i].wvM;
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.xA", i), E_valA, vecs[i].xA);
            chk($sformatf("vec%0d.xB", i), E_valB, vecs[i].xB);
            chk($sformatf("vec%0d.xdE", i), {60'd0, E_dstE}, {60'd0, vecs[i].xdE});
            chk($sformatf("vec%0d.xdM", i), {60'd0, E_dstM}, {60'd0, vecs[i].xdM});
            chk($sformatf("vec%0d.xsA", i), {60'd0, E_srcA}, {60'd0, vecs[i].xsA});
            chk($sformatf("vec%0d.xsB", i), {60'd0, E_srcB}, {60'd0, vecs[i].xsB});
        end

        set_idle();
        D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h5;
        tick("stall_load");
        E_stall = 1'b1;
        D_icode = 4'h3; D_rB = 4'h9; D_valC = 64'hDEAD;
        tick("stall1");
        tick("stall2");
        chk("stall.held_icode", {60'd0, E_icode}, 64'd6);
        chk("stall.held_valA", E_valA, 64'd33);
        E_bubble = 1'b1;
        tick("stall_bubble");
        chk("stall_bubble.icode", {60'd0, E_icode}, 64'd1);
        chk("stall_bubble.dstE", {60'd0, E_dstE}, 64'hF);

        for (int i = 0; i < 400; i++) begin
            D_stat = 4'($urandom_range(1, 4));
            D_icode = 4'($urandom_range(0, 11));
            D_ifun = 4'($urandom);
            D_rA = 4'($urandom); D_rB = 4'($urandom);
            D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
            e_dstE = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            M_dstE = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            M_dstM = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            W_dstE = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            W_dstM = ($urandom_range(0, 2) != 0) ? 4'hF : (($urandom_range(0, 3) == 0) ? W_dstE : 4'($urandom));
            e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
            m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
            W_valM = {$urandom, $urandom};
            E_stall = ($urandom_range(0, 9) == 0);
            E_bubble = ($urandom_range(0, 19) == 0);
            tick("rand");
        end

        set_idle();
        D_icode = 4'h6; D_rA = 4'h7; D_rB = 4'h3;
        W_dstE = 4'h3; W_valE = 64'd99;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_e("mid_reset");
        chk("mid_reset.d_srcA", {60'd0, d_srcA}, 64'd7);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_idle();
        D_icode = 4'h4; D_rA = 4'h3; D_rB = 4'h4;
        tick("after_reset");
        chk("after_reset.reg3_zero", E_valA, 64'd0);
        chk("after_reset.reg4_zero", E_valB, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/y86_decode_stage.md
Name: y86_decode_stage

Overview:
- Parametrised pipelined decode stage for the Y86-64 processor.
- Holds the architectural register file and performs source/destination selection from the D-stage fields.
- Forwards in-flight results from the E, M and W stages and registers the outcome into the E pipeline register.
- Generalises the earlier single-cycle decode: configurable width and register count, two write-back ports, five-source forwarding, and stall/bubble control.

Parameters:
- DATA_W, 64, datapath width of register values, valC and valP.
- NUM_REGS, 15, number of architectural registers; legal indices are 0..NUM_REGS-1.
- REG_AW, 4, register index width; index 2^REG_AW-1 (0xF) means "no register" (RNONE).
- RSP_IDX, 4, index of the stack pointer.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- D_stat  in  4  D-stage status.
- D_icode  in  4  D-stage instruction code.
- D_ifun  in  4  D-stage function code.
- D_rA  in  REG_AW  register field A.
- D_rB  in  REG_AW  register field B.
- D_valC  in  DATA_W  constant word.
- D_valP  in  DATA_W  incremented PC.
- e_dstE  in  REG_AW  E-stage destination E, post-cmov.
- e_valE  in  DATA_W  ALU result in E.
- M_dstE  in  REG_AW  M-stage destination E.
- M_valE  in  DATA_W  M-stage valE.
- M_dstM  in  REG_AW  M-stage destination M.
- m_valM  in  DATA_W  memory read data in M.
- W_dstE  in  REG_AW  write-back destination E.
- W_valE  in  DATA_W  write-back valE.
- W_dstM  in  REG_AW  write-back destination M.
- W_valM  in  DATA_W  write-back valM.
- E_stall  in  1  hold the E register.
- E_bubble  in  1  load a bubble into the E register.
- E_stat, E_icode, E_ifun  out  4 each  E pipeline register fields.
- E_valC, E_valA, E_valB  out  DATA_W each  E pipeline register fields.
- E_dstE, E_dstM, E_srcA, E_srcB  out  REG_AW each  E pipeline register fields.
- d_srcA, d_srcB  out  REG_AW each  combinational source indices, for the hazard unit.

Behaviour:
- Opcodes: HALT 0, NOP 1, CMOV/RRMOV 2, IRMOV 3, RMMOV 4, MRMOV 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSH A, POP B.
- d_srcA: rA for 2, 4, 6, A; RSP_IDX for 9, B; else RNONE.
- d_srcB: rB for 4, 5, 6; RSP_IDX for 8, 9, A, B; else RNONE.
- d_dstE: rB for 2, 3, 6; RSP_IDX for 8, 9, A, B; else RNONE.
- d_dstM: rA for 5, B; else RNONE.
- d_valA: D_valP for icode 7 or 8. Otherwise forwarded value for d_srcA.
- d_valB: forwarded value for d_srcB.
- Forwarding priority, first match wins:
  1. e_dstE → e_valE
  2. M_dstM → m_valM
  3. M_dstE → M_valE
  4. W_dstM → W_valM
  5. W_dstE → W_valE
  6. register file
- A source equal to RNONE never matches a forwarding source and reads 0.
- A source index ≥ NUM_REGS that is not RNONE also reads 0.
- Register file: NUM_REGS × DATA_W flops.
  - Two write ports, W_dstE/W_valE and W_dstM/W_valM, written on the rising clk edge.
  - Writes to RNONE or to indices ≥ NUM_REGS are ignored.
  - If W_dstE == W_dstM, W_valM wins; this is the popq %rsp rule.
  - Reads are combinational. A same-cycle write is visible only through forwarding priorities 4/5, so results are always write-first.
- E register update, on the rising edge, in priority order:
  1. E_bubble=1: load a bubble (stat=AOK 1, icode=NOP, ifun=0, all dst/src=RNONE, values 0). Bubble wins over E_stall.
  2. E_stall=1: hold all E outputs.
  3. Otherwise: load the D fields and the computed d_* values.
- Latency: one cycle from D inputs to E outputs.
- Reset (rst_n=0, asynchronous): all registers clear to 0; E register takes bubble values.
  - Release is synchronous to the next clk edge.
  - Reset mid-operation discards any in-flight write.
- d_srcA/d_srcB are purely combinational from the D inputs and are valid during reset.

Decomposition:
- Package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ);
  - stat codes (S_AOK 1, S_HLT 2, S_ADR 3, S_INS 4);
  - RNONE and RSP_IDX defaults;
  - the bubble field values.
- Sub-module y86_regfile: parametrised 2-read/2-write array carrying the write-collision rule. The decode stage instantiates it once.

Test Plan:
- Reset then release: E_icode=1, E_dstE=E_dstM=0xF, all registers read 0 via D_icode=6, rA=1, rB=2 → E_valA=0, E_valB=0.
- Write W_dstE=3/W_valE=33 and W_dstM=5/W_valM=55 in one cycle, then decode opq rA=3 rB=5 with no forwarding → E_valA=33, E_valB=55.
- Forward priority: e_dstE=M_dstM=2 (e_valE=7, m_valM=9), decode rrmovq rA=2 → E_valA=7. Then drop e_dstE to 0xF → E_valA=9.
- call, D_valP=0x40 → E_valA=0x40, E_srcB=4, E_dstE=4. popq rA=6 → E_dstM=6, E_dstE=4, E_srcA=E_srcB=4.
- W_dstE=W_dstM=4 with valE=0x10 and valM=0x20 → register 4 reads 0x20 the next cycle.
- E_stall=1 for 2 cycles → outputs held. E_stall=E_bubble=1 → bubble loaded. rst_n pulled low mid-stream → E bubble immediately, registers 0, with no clk edge needed.
